// File: rtl/remote_comm.sv
// Remote command link: 3-byte 8N1 command frame out on TX, single-byte responses in on RX.
// Optional feature macro: RESP_TIMEOUT_EN (adds WAIT_RESP state and response timeout).
module remote_comm #(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        clr_resp_rdy,
    input  logic        RX,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        resp_timeout
);

    localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'((BAUD_DIV / 2) - 1);

`ifdef RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, TX_CMD, TX_DH, TX_DL, WAIT_RESP
    } state_t;

    logic [TW-1:0] to_cnt;
    logic          rx_done;
`else
    typedef enum logic [1:0] {
        IDLE, TX_CMD, TX_DH, TX_DL
    } state_t;
`endif

    state_t      state;
    logic [23:0] shreg;
    logic [7:0]  cur_byte;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_idx;
    logic        accept;

    logic        rx_s1, rx_s2, rx_s3;
    logic        rx_active;
    logic [11:0] rx_cnt;
    logic [3:0]  rx_bit;
    logic [7:0]  rx_shift;

    assign accept   = snd_cmd && !busy;
    assign cur_byte = shreg[23:16];

    // Transmit FSM: frame sequencing, bit timing, busy and cmd_sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            TX       <= 1'b1;
            busy     <= 1'b0;
            cmd_sent <= 1'b0;
            shreg    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
`ifdef RESP_TIMEOUT_EN
            to_cnt       <= '0;
            resp_timeout <= 1'b0;
`endif
        end else begin
            cmd_sent <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            resp_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= {cmd, data};
                        state    <= TX_CMD;
                        busy     <= 1'b1;
                        TX       <= 1'b0;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                    end
                end
                TX_CMD, TX_DH, TX_DL: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            bit_idx <= '0;
                            shreg   <= {shreg[15:0], 8'h00};
                            if (state == TX_DL) begin
                                TX       <= 1'b1;
                                cmd_sent <= 1'b1;
`ifdef RESP_TIMEOUT_EN
                                state  <= WAIT_RESP;
                                to_cnt <= '0;
`else
                                state <= IDLE;
                                busy  <= 1'b0;
`endif
                            end else begin
                                TX    <= 1'b0;
                                state <= (state == TX_CMD) ? TX_DH : TX_DL;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx == 4'd8)
                                TX <= 1'b1;
                            else
                                TX <= cur_byte[bit_idx[2:0]];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
`ifdef RESP_TIMEOUT_EN
                WAIT_RESP: begin
                    if (rx_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        resp_timeout <= 1'b1;
                        state        <= IDLE;
                        busy         <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifndef RESP_TIMEOUT_EN
    assign resp_timeout = 1'b0;
`endif

    // RX synchronizer plus one extra stage for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Receiver: mid-bit sampling, framing check, resp/resp_rdy update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_active <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            resp      <= 8'h00;
            resp_rdy  <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            rx_done   <= 1'b0;
`endif
        end else begin
`ifdef RESP_TIMEOUT_EN
            rx_done <= 1'b0;
`endif
            if (clr_resp_rdy || accept)
                resp_rdy <= 1'b0;
            if (!rx_active) begin
                if (rx_s3 && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= '0;
                    rx_bit    <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt <= '0;
                    if (rx_s2)
                        rx_active <= 1'b0;
                    else
                        rx_bit <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + 12'd1;
                end
            end else if (rx_cnt == BIT_LAST) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    rx_bit    <= '0;
                    if (rx_s2) begin
                        resp     <= rx_shift;
                        resp_rdy <= 1'b1;
`ifdef RESP_TIMEOUT_EN
                        rx_done  <= 1'b1;
`endif
                    end
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_remote_comm.sv
// Randomized self-checking bench for remote_comm (BAUD_DIV=8, TIMEOUT_CYC=400).
// Build with +define+RESP_TIMEOUT_EN to exercise the response-timeout variant.
module tb_remote_comm;

    localparam int BD = 8;
    localparam int TO = 400;

    logic        clk;
    logic        rst_n;
    logic        snd_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_resp_rdy;
    logic        RX;
    logic        TX;
    logic        busy;
    logic        cmd_sent;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        resp_timeout;

    int tests;
    int fails;
    int sent_pulses;
    int to_pulses;

    logic [7:0] resp_m;
    logic       rdy_m;

    remote_comm #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .snd_cmd(snd_cmd),
        .cmd(cmd),
        .data(data),
        .clr_resp_rdy(clr_resp_rdy),
        .RX(RX),
        .TX(TX),
        .busy(busy),
        .cmd_sent(cmd_sent),
        .resp(resp),
        .resp_rdy(resp_rdy),
        .resp_timeout(resp_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // pulse monitors, sampled away from the active edge
    initial begin
        sent_pulses = 0;
        to_pulses = 0;
        forever begin
            @(negedge clk);
            if (cmd_sent === 1'b1) sent_pulses++;
            if (resp_timeout === 1'b1) to_pulses++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected TX level k clocks after the start bit of a 3-byte frame
    function automatic logic exp_bit(input logic [23:0] f, input int k);
        int by;
        int bt;
        logic [7:0] b;
        by = k / (10 * BD);
        bt = (k % (10 * BD)) / BD;
        b = f[23 - 8 * by -: 8];
        if (bt == 0) return 1'b0;
        if (bt == 9) return 1'b1;
        return b[bt - 1];
    endfunction

    task automatic send_frame(input logic [7:0] c, input logic [15:0] d,
                              input int inj);
        int errs;
        int p0;
        errs = 0;
        p0 = sent_pulses;
        cmd = c;
        data = d;
        snd_cmd = 1'b1;
        step();
        snd_cmd = 1'b0;
        rdy_m = 1'b0;
        chk("acc_clr_rdy", resp_rdy, rdy_m);
        for (int k = 0; k < 30 * BD; k++) begin
            if (TX !== exp_bit({c, d}, k)) errs++;
            if (busy !== 1'b1 || cmd_sent !== 1'b0) errs++;
            if (k == inj) begin
                snd_cmd = 1'b1;
                cmd = ~c;
                data = ~d;
            end else begin
                snd_cmd = 1'b0;
            end
            step();
        end
        snd_cmd = 1'b0;
        chk("tx_wave", errs, 0);
        chk("cmd_sent_at_240", cmd_sent, 1);
        chk("tx_idle_high", TX, 1);
`ifdef RESP_TIMEOUT_EN
        chk("busy_wait_resp", busy, 1);
`else
        chk("busy_falls", busy, 0);
`endif
        step();
        chk("cmd_sent_once", sent_pulses - p0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk("wait_idle_bound", busy, 0);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (BD) step();
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) step();
        end
        RX = stop;
        repeat (BD) step();
        RX = 1'b1;
        repeat (4) step();
        if (stop) begin
            resp_m = b;
            rdy_m = 1'b1;
        end
        chk("rx_resp", resp, resp_m);
        chk("rx_rdy", resp_rdy, rdy_m);
    endtask

    initial begin
        int errs;
        int p0;
        int t0;
        logic [7:0] rb;
        logic [15:0] rd;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        snd_cmd = 1'b0;
        cmd = '0;
        data = '0;
        clr_resp_rdy = 1'b0;
        RX = 1'b1;
        resp_m = 8'h00;
        rdy_m = 1'b0;
        repeat (3) step();
        chk("rst_tx", TX, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_sent", cmd_sent, 0);
        chk("rst_resp", resp, 8'h00);
        chk("rst_rdy", resp_rdy, 0);
        chk("rst_timeout", resp_timeout, 0);
        rst_n = 1'b1;
        repeat (3) step();

        send_frame(8'h02, 16'hA55A, -1);
`ifdef RESP_TIMEOUT_EN
        errs = 0;
        repeat (TO - 2) begin
            step();
            if (resp_timeout !== 1'b0 || busy !== 1'b1) errs++;
        end
        chk("to_quiet", errs, 0);
        step();
        chk("to_pulse", resp_timeout, 1);
        chk("to_busy_low", busy, 0);
        step();
        chk("to_pulse_end", resp_timeout, 0);
`endif

        send_frame(8'h02, 16'hA55A, 37);
        wait_idle();

        rx_byte(8'hA5, 1'b1);
        clr_resp_rdy = 1'b1;
        step();
        clr_resp_rdy = 1'b0;
        rdy_m = 1'b0;
        chk("clr_rdy", resp_rdy, rdy_m);

        rx_byte(8'h3C, 1'b0);
        repeat (2 * BD) step();

        RX = 1'b0;
        repeat (3) step();
        RX = 1'b1;
        repeat (20 * BD) step();
        chk("glitch_rdy", resp_rdy, rdy_m);
        chk("glitch_resp", resp, resp_m);

        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom);
            rx_byte(rb, ($urandom_range(0, 3) != 0));
            repeat (2 * BD) step();
            if ($urandom_range(0, 1) == 1) begin
                clr_resp_rdy = 1'b1;
                step();
                clr_resp_rdy = 1'b0;
                rdy_m = 1'b0;
                chk("rand_clr", resp_rdy, rdy_m);
            end
        end

`ifdef RESP_TIMEOUT_EN
        send_frame(8'h11, 16'h0001, -1);
        t0 = to_pulses;
        rx_byte(8'h0A, 1'b1);
        chk("reply_busy_low", busy, 0);
        repeat (TO + 20) step();
        chk("reply_no_timeout", to_pulses - t0, 0);
`endif

        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            rd = 16'($urandom);
            send_frame(rb, rd, int'($urandom_range(0, 30 * BD - 2)));
            wait_idle();
        end

        cmd = 8'h11;
        data = 16'h2233;
        snd_cmd = 1'b1;
        step();
        snd_cmd = 1'b0;
        repeat (100) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", TX, 1);
        chk("midrst_busy", busy, 0);
        p0 = sent_pulses;
        step();
        step();
        rst_n = 1'b1;
        resp_m = 8'h00;
        rdy_m = 1'b0;
        errs = 0;
        repeat (300) begin
            if (TX !== 1'b1 || cmd_sent !== 1'b0) errs++;
            step();
        end
        chk("midrst_quiet", errs + (sent_pulses - p0), 0);
        chk("midrst_resp", resp, resp_m);
        chk("midrst_rdy", resp_rdy, rdy_m);
        send_frame(8'h02, 16'hA55A, -1);
        wait_idle();

`ifndef RESP_TIMEOUT_EN
        chk("no_timeout_ever", to_pulses, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
